instr_mem_pipe: RTL and testbench

//  Parametrised, pipelined instruction memory for the fetch stage. Replaces the fixed 2-bank ROM with
//  N synchronous banks, a valid/ready request/response handshake, and an output buffer so fetch stalls lose no data.

---
 rtl/instr_mem_pkg.sv | 45 ++++
 rtl/instr_mem_pipe_bank.sv | 62 ++++++
 rtl/instr_mem_pipe.sv | 163 ++++++++++++++++
 tb/tb_instr_mem_pipe.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_mem_pkg                                                |
// | Description : Shared constants, response entry type and address decode    |
// |               helpers for the pipelined instruction memory.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package instr_mem_pkg;

   // RISC-V style NOP, returned for faulted fetches
   localparam logic [31:0] c_nop_instr   = 32'h0000_0013;
   localparam int          c_def_instr_w = 32;

   // Response entry pattern: fault flag above the instruction word
   typedef struct packed {
      logic                     fault;
      logic [c_def_instr_w-1:0] instr;
   } rsp_entry_t;

   // Misaligned (low offset bits set) or beyond the last word (bits above the index set)
   function automatic logic addr_fault(input logic [63:0] addr,
                                       input int unsigned ofs,
                                       input int unsigned word_aw);
      logic [63:0] low_mask;
      low_mask = (64'd1 << ofs) - 64'd1;
      return ((addr & low_mask) != 64'd0) || ((addr >> (ofs + word_aw)) != 64'd0);
   endfunction

   // Word index inside a bank; the read and write paths share this decode
   function automatic logic [31:0] word_idx(input logic [63:0] addr,
                                            input int unsigned ofs,
                                            input int unsigned word_aw);
      logic [63:0] idx_mask;
      idx_mask = (64'd1 << word_aw) - 64'd1;
      return 32'((addr >> ofs) & idx_mask);
   endfunction

   // Power-up image of a read-only bank: bank b, word i holds i*40503 + b*4660 + 23130
   function automatic logic [31:0] image_word(input int unsigned bank,
                                              input int unsigned idx);
      return 32'(idx * 32'd40503 + bank * 32'd4660 + 32'd23130);
   endfunction

endpackage
`default_nettype wire

// File: rtl/instr_mem_pipe_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_bank                                                   |
// | Description : One BANK_W x DEPTH synchronous-read bank with active-low     |
// |               chip enable, optional write port and a built-in ROM image.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instr_bank
   import instr_mem_pkg::*;
#(
   parameter int BANK_W   = 16,
   parameter int DEPTH    = 512,
   parameter int BANK_IDX = 0,
   parameter int WRITABLE = 0
) (
   input  logic                     clk,
   input  logic                     cen_n,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [BANK_W-1:0]        wdata,
   output logic [BANK_W-1:0]        q
);

   logic [BANK_W-1:0] r_q;

   assign q = r_q;

   if (WRITABLE != 0) begin : g_ram
      // The image is only used by the ROM flavour; a RAM is boot-loaded through the write port
      localparam int c_unused_bank_idx = BANK_IDX;

      logic [BANK_W-1:0] r_mem [DEPTH];

      // Write port, independent of the read address
      always_ff @(posedge clk) begin
         if (we) begin
            r_mem[waddr] <= wdata;
         end
      end

      // Read port; non-blocking update means a same-edge write to this word is not seen (read-before-write)
      always_ff @(posedge clk) begin
         if (!cen_n) begin
            r_q <= r_mem[addr];
         end
      end
   end else begin : g_rom
      logic w_unused_wr;

      assign w_unused_wr = ^{we, waddr, wdata};

      // Read-only bank: contents come from the fixed image, so writes have nowhere to land
      always_ff @(posedge clk) begin
         if (!cen_n) begin
            r_q <= BANK_W'(image_word(BANK_IDX, 32'(addr)));
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/instr_mem_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_mem_pipe                                               |
// | Description : Pipelined, banked instruction memory for the fetch stage.    |
// |               valid/ready request and response, stage-1 read register and  |
// |               an output FIFO so decode stalls never drop a fetch.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instr_mem_pipe
   import instr_mem_pkg::*;
#(
   parameter int                 INSTR_W     = 32,
   parameter int                 BANK_W      = 16,
   parameter int                 DEPTH       = 512,
   parameter int                 ADDR_W      = 32,
   parameter int                 OBUF_DEPTH  = 3,
   parameter int                 WRITABLE    = 0,
   parameter logic [INSTR_W-1:0] FAULT_INSTR = INSTR_W'(c_nop_instr)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [ADDR_W-1:0]  req_addr,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [INSTR_W-1:0] rsp_instr,
   output logic               rsp_fault,
   input  logic               wr_en,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [INSTR_W-1:0] wr_data
);

   localparam int c_num_banks = INSTR_W / BANK_W;
   localparam int c_word_aw   = $clog2(DEPTH);
   localparam int c_ofs       = $clog2(INSTR_W / 8);
   localparam int c_ptr_w     = $clog2(OBUF_DEPTH);
   localparam int c_cnt_w     = $clog2(OBUF_DEPTH + 1);

   localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(OBUF_DEPTH - 1);
   localparam logic [c_cnt_w-1:0] c_obuf_cnt = c_cnt_w'(OBUF_DEPTH);

   typedef struct packed {
      logic               fault;
      logic [INSTR_W-1:0] instr;
   } buf_entry_t;

   // Circular pointer advance; OBUF_DEPTH need not be a power of two
   function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
      return (p == c_last_ptr) ? '0 : p + c_ptr_w'(1);
   endfunction

   // Request-side decode
   logic                 w_rd_fault;
   logic [c_word_aw-1:0] w_rd_idx;
   logic                 w_accept;
   logic                 w_bank_cen_n;

   // Write-side decode
   logic                 w_wr_fault;
   logic [c_word_aw-1:0] w_wr_idx;
   logic                 w_wr_en;

   // Stage 1 and bank outputs
   logic                 r_s1_valid;
   logic                 r_s1_fault;
   logic [INSTR_W-1:0]   w_bank_q;
   buf_entry_t           w_s1_entry;

   // Output FIFO
   buf_entry_t           r_buf [OBUF_DEPTH];
   logic [c_ptr_w-1:0]   r_wr_ptr;
   logic [c_ptr_w-1:0]   r_rd_ptr;
   logic [c_cnt_w-1:0]   r_count;
   logic                 w_push;
   logic                 w_pop;
   buf_entry_t           w_head;

   assign w_rd_fault = addr_fault(64'(req_addr), c_ofs, c_word_aw);
   assign w_rd_idx   = c_word_aw'(word_idx(64'(req_addr), c_ofs, c_word_aw));
   assign w_wr_fault = addr_fault(64'(wr_addr), c_ofs, c_word_aw);
   assign w_wr_idx   = c_word_aw'(word_idx(64'(wr_addr), c_ofs, c_word_aw));

   // Everything accepted but not yet popped occupies a buffer slot, so the
   // stage-1 entry can always be pushed on the next edge without a stall.
   assign req_ready    = !rst && ((r_count + c_cnt_w'(r_s1_valid)) < c_obuf_cnt);
   assign w_accept     = req_valid && req_ready;
   // Faulted fetches leave the banks idle
   assign w_bank_cen_n = !(w_accept && !w_rd_fault);
   assign w_wr_en      = (WRITABLE != 0) && wr_en && !w_wr_fault;

   for (genvar k = 0; k < c_num_banks; k++) begin : g_bank
      instr_bank #(
         .BANK_W   (BANK_W),
         .DEPTH    (DEPTH),
         .BANK_IDX (k),
         .WRITABLE (WRITABLE)
      ) u_bank (
         .clk   (clk),
         .cen_n (w_bank_cen_n),
         .addr  (w_rd_idx),
         .we    (w_wr_en),
         .waddr (w_wr_idx),
         .wdata (wr_data[k*BANK_W +: BANK_W]),
         .q     (w_bank_q[k*BANK_W +: BANK_W])
      );
   end

   // Stage 1 tracks the fetch whose bank read was issued at the last edge
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_fault <= 1'b0;
      end else begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_fault <= w_rd_fault;
         end
      end
   end

   // A faulted entry never exposes the (stale) bank registers
   assign w_s1_entry.fault = r_s1_fault;
   assign w_s1_entry.instr = r_s1_fault ? FAULT_INSTR : w_bank_q;

   assign w_push = r_s1_valid;
   assign w_pop  = rsp_valid && rsp_ready;

   // FIFO storage; contents need no reset because the count gates visibility
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_buf[r_wr_ptr] <= w_s1_entry;
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop keep the count
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= ptr_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_cnt_w'(1);
            2'b01:   r_count <= r_count - c_cnt_w'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign w_head    = r_buf[r_rd_ptr];
   assign rsp_valid = (r_count != '0);
   assign rsp_instr = rsp_valid ? w_head.instr : '0;
   assign rsp_fault = rsp_valid && w_head.fault;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_instr_mem_pipe                                            |
// | Description : Self-checking bench: a writable 32-bit instance checked      |
// |               cycle by cycle against a queue-based model, and a 64-bit     |
// |               ROM instance checked against the built-in image.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_instr_mem_pipe;

   localparam int OBUF = 3;

   logic        clk;
   logic        rst;

   // 32-bit writable instance
   logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_fault, wr_en;
   logic [31:0] req_addr, rsp_instr, wr_addr, wr_data;

   // 64-bit read-only instance
   logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_fault, b_wr_en;
   logic [31:0] b_req_addr, b_wr_addr;
   logic [63:0] b_rsp_instr, b_wr_data;

   instr_mem_pipe #(
      .INSTR_W(32), .BANK_W(16), .DEPTH(512), .ADDR_W(32), .OBUF_DEPTH(OBUF), .WRITABLE(1)
   ) dut_a (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_fault(rsp_fault),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   instr_mem_pipe #(
      .INSTR_W(64), .BANK_W(16), .DEPTH(1024), .ADDR_W(32), .OBUF_DEPTH(3), .WRITABLE(0)
   ) dut_b (
      .clk(clk), .rst(rst),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_instr(b_rsp_instr), .rsp_fault(b_rsp_fault),
      .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: every accepted fetch becomes visible two edges later, in order
   typedef struct {
      logic [31:0] instr;
      logic        fault;
      int          vis;
   } ent_t;

   ent_t        q[$];
   logic [31:0] mem_model [512];
   logic [31:0] dut_rsp[$];
   int          cyc, checks, errors, dut_acc, dut_pop;

   function automatic ent_t model_fetch(input logic [31:0] a, input int vis);
      ent_t e;
      e.vis = vis;
      if (a[1:0] != 2'b00 || (a >> 2) >= 32'd512) begin
         e.fault = 1'b1;
         e.instr = 32'h0000_0013;
      end else begin
         e.fault = 1'b0;
         e.instr = mem_model[a[10:2]];
      end
      return e;
   endfunction

   // One clock of dut_a: compare outputs at the falling edge, advance the model, cross the rising edge
   task automatic tick();
      logic exp_ready, exp_valid, acc, pop, exp_cen_n;
      ent_t e;
      @(negedge clk);
      exp_ready = !rst && (q.size() < OBUF);
      exp_valid = (q.size() > 0) && (q[0].vis <= cyc);
      checks++;
      if (req_ready !== exp_ready) begin
         errors++;
         $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready);
      end
      checks++;
      if (rsp_valid !== exp_valid) begin
         errors++;
         $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_valid);
      end
      if (exp_valid) begin
         checks++;
         if (rsp_instr !== q[0].instr || rsp_fault !== q[0].fault) begin
            errors++;
            $display("FAIL rsp_data cyc=%0d got=%h/%b exp=%h/%b",
                     cyc, rsp_instr, rsp_fault, q[0].instr, q[0].fault);
         end
      end
      if (req_valid && req_ready) dut_acc++;
      if (rsp_valid && rsp_ready) begin
         dut_pop++;
         dut_rsp.push_back(rsp_instr);
      end
      acc = req_valid && exp_ready;
      pop = exp_valid && rsp_ready;
      e   = model_fetch(req_addr, cyc + 2);
      exp_cen_n = !(acc && !e.fault);
      checks++;
      if (dut_a.w_bank_cen_n !== exp_cen_n) begin
         errors++;
         $display("FAIL bank_cen cyc=%0d got=%b exp=%b", cyc, dut_a.w_bank_cen_n, exp_cen_n);
      end
      if (rst) begin
         q.delete();
      end else begin
         if (pop) void'(q.pop_front());
         if (acc) q.push_back(e);
      end
      // Read-before-write: the fetch above already captured the old word
      if (wr_en && wr_addr[1:0] == 2'b00 && (wr_addr >> 2) < 32'd512)
         mem_model[wr_addr[10:2]] = wr_data;
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic drain();
      int n;
      req_valid = 1'b0;
      wr_en     = 1'b0;
      rsp_ready = 1'b1;
      n = 0;
      while (q.size() > 0 && n < 20) begin
         tick();
         n++;
      end
      tick();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout left=%0d", q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      tick();
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || rsp_fault !== 1'b0 || rsp_instr !== 32'd0) begin
         errors++;
         $display("FAIL reset_outputs got=%b/%b/%h exp=0/0/0", rsp_valid, rsp_fault, rsp_instr);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic boot_load();
      for (int w = 0; w < 64; w++) begin
         wr_en   = 1'b1;
         wr_addr = 32'(w * 4);
         wr_data = $urandom;
         tick();
      end
      wr_en = 1'b0;
   endtask

   task automatic test_back_to_back();
      int p0;
      p0 = dut_pop;
      rsp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         req_valid = 1'b1;
         req_addr  = 32'(i * 4);
         tick();
      end
      drain();
      checks++;
      if (dut_pop - p0 != 8) begin
         errors++;
         $display("FAIL b2b_count got=%0d exp=8", dut_pop - p0);
      end
   endtask

   task automatic test_fault();
      logic [31:0] addrs [2];
      addrs[0] = 32'h0000_0002;
      addrs[1] = 32'h0000_0800;
      rsp_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         req_valid = 1'b1;
         req_addr  = addrs[i];
         tick();
      end
      drain();
      checks++;
      if (dut_rsp.size() < 2 || dut_rsp[$] !== 32'h0000_0013 || dut_rsp[$-1] !== 32'h0000_0013) begin
         errors++;
         $display("FAIL fault_instr got_last=%h exp=00000013", (dut_rsp.size() > 0) ? dut_rsp[$] : 32'hx);
      end
   endtask

   task automatic test_stall();
      int a0, p0;
      a0 = dut_acc;
      rsp_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         req_valid = 1'b1;
         req_addr  = 32'($urandom_range(63) * 4);
         tick();
      end
      checks++;
      if (dut_acc - a0 != OBUF) begin
         errors++;
         $display("FAIL stall_accepts got=%0d exp=%0d", dut_acc - a0, OBUF);
      end
      p0 = dut_pop;
      drain();
      checks++;
      if (dut_pop - p0 != OBUF) begin
         errors++;
         $display("FAIL stall_drained got=%0d exp=%0d", dut_pop - p0, OBUF);
      end
   endtask

   task automatic test_write_rbw();
      logic [31:0] old_word;
      old_word  = mem_model[4];
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_addr  = 32'h10;
      wr_en     = 1'b1;
      wr_addr   = 32'h10;
      wr_data   = 32'hDEAD_BEEF;
      tick();
      wr_en = 1'b0;
      tick();
      drain();
      checks++;
      if (dut_rsp.size() < 2 || dut_rsp[$-1] !== old_word || dut_rsp[$] !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL write_rbw got=%h,%h exp=%h,deadbeef",
                  (dut_rsp.size() > 1) ? dut_rsp[$-1] : 32'hx,
                  (dut_rsp.size() > 0) ? dut_rsp[$] : 32'hx, old_word);
      end
   endtask

   task automatic test_reset_mid();
      int p0;
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req_valid = 1'b1;
         req_addr  = 32'((8 + i) * 4);
         tick();
      end
      req_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_valid got=%b exp=0", rsp_valid);
      end
      p0 = dut_pop;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (dut_pop != p0) begin
         errors++;
         $display("FAIL reset_mid_stale got=%0d exp=0", dut_pop - p0);
      end
      for (int i = 0; i < 3; i++) begin
         req_valid = 1'b1;
         req_addr  = 32'((8 + i) * 4);
         tick();
      end
      drain();
   endtask

   task automatic test_random();
      int r;
      for (int n = 0; n < 300; n++) begin
         req_valid = ($urandom_range(99) < 75);
         rsp_ready = ($urandom_range(99) < 70);
         r = int'($urandom_range(99));
         if (r < 80)      req_addr = 32'($urandom_range(63) * 4);
         else if (r < 90) req_addr = 32'($urandom_range(63) * 4 + $urandom_range(1, 3));
         else             req_addr = 32'($urandom_range(1023, 512) * 4) | (($urandom_range(1) == 1) ? 32'h8000_0000 : 32'h0);
         wr_en   = ($urandom_range(99) < 25);
         wr_addr = 32'($urandom_range(63) * 4 + (($urandom_range(9) == 0) ? 2 : 0));
         wr_data = $urandom;
         tick();
      end
      drain();
   endtask

   // ROM image as defined for the read-only banks: bank k, word i = i*40503 + k*4660 + 23130
   function automatic logic [63:0] wide_image(input int idx);
      logic [63:0] v;
      logic [31:0] t;
      for (int k = 0; k < 4; k++) begin
         t = 32'(idx * 40503 + k * 4660 + 23130);
         v[16*k +: 16] = t[15:0];
      end
      return v;
   endfunction

   task automatic test_wide();
      int          idx;
      logic [63:0] exp_i;
      logic        exp_f;
      b_rsp_ready = 1'b1;
      // A write to a ROM instance must leave the image untouched
      b_wr_en   = 1'b1;
      b_wr_addr = 32'(5 * 8);
      b_wr_data = {$urandom, $urandom};
      @(posedge clk);
      #1;
      b_wr_en = 1'b0;
      for (int n = 0; n < 12; n++) begin
         idx = (n == 0) ? 5 : ((n == 11) ? 1024 : int'($urandom_range(1023)));
         exp_f = (idx >= 1024);
         exp_i = exp_f ? 64'h13 : wide_image(idx);
         b_req_valid = 1'b1;
         b_req_addr  = 32'(idx * 8);
         @(negedge clk);
         checks++;
         if (b_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL wide_ready n=%0d got=%b exp=1", n, b_req_ready);
         end
         @(posedge clk);
         #1;
         b_req_valid = 1'b0;
         @(posedge clk);
         #1;
         @(negedge clk);
         checks++;
         if (b_rsp_valid !== 1'b1 || b_rsp_instr !== exp_i || b_rsp_fault !== exp_f) begin
            errors++;
            $display("FAIL wide_data idx=%0d got=%b/%h/%b exp=1/%h/%b",
                     idx, b_rsp_valid, b_rsp_instr, b_rsp_fault, exp_i, exp_f);
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0; dut_acc = 0; dut_pop = 0;
      rst = 1'b1;
      req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      b_req_valid = 1'b0; b_req_addr = '0; b_rsp_ready = 1'b0;
      b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
      test_reset();
      boot_load();
      test_back_to_back();
      test_fault();
      test_stall();
      test_write_rbw();
      test_reset_mid();
      test_random();
      test_wide();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
